// File: rtl/queue.sv
// Show-ahead FIFO with global enable, independent push/pop strobes,
// occupancy flags and sticky overflow/underflow error flags.
module queue #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] head_reg, tail_reg;
    logic [ADDR_WIDTH:0]   count_reg;
    logic                  overflow_reg, underflow_reg;
    logic                  do_push, do_pop;

    assign full  = (count_reg == FULL_COUNT);
    assign empty = (count_reg == '0);

    // A push into a full queue is only accepted when a pop frees the head slot
    // on the same edge.
    assign do_push = en & push & (~full | pop);
    assign do_pop  = en & pop & ~empty;

    // Storage is deliberately left out of reset; the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[tail_reg] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_reg      <= '0;
            tail_reg      <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (do_push) begin
                tail_reg <= tail_reg + ADDR_WIDTH'(1);
            end
            if (do_pop) begin
                head_reg <= head_reg + ADDR_WIDTH'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (ADDR_WIDTH + 1)'(1);
                2'b01:   count_reg <= count_reg - (ADDR_WIDTH + 1)'(1);
                default: count_reg <= count_reg;
            endcase
            if (en && push && full && !pop) begin
                overflow_reg <= 1'b1;
            end
            if (en && pop && empty) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    assign data_out  = empty ? '0 : mem[head_reg];
    assign count     = count_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

endmodule

// File: doc/queue.md
# queue

FIFO counterpart to the CPU's LIFO `stack`: values are written at the tail and read from the opposite end (head), in arrival order. It buffers data between a producer stage and a consumer stage of the core, for example instruction prefetch or memory write-back. It keeps the `stack` control style: a global `en` gate and a show-ahead `data_out`. It adds independent push/pop strobes, occupancy flags and sticky error flags.

## Interface
Parameters:
- DATA_WIDTH, 8, width of each stored word
- ADDR_WIDTH, 4, pointer width; depth = 2**ADDR_WIDTH (default 16 entries)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- en  input  1  block enable; when 0, all state holds and push/pop are ignored
- push  input  1  write data_in at tail this cycle
- pop  input  1  remove head entry this cycle
- data_in  input  DATA_WIDTH  word to write
- data_out  output  DATA_WIDTH  current head word (show-ahead), 0 when empty
- full  output  1  count == 2**ADDR_WIDTH
- empty  output  1  count == 0
- count  output  ADDR_WIDTH+1  number of stored entries
- overflow  output  1  sticky: push attempted while full and not accepted
- underflow  output  1  sticky: pop attempted while empty

## Operation
- Storage: register array of 2**ADDR_WIDTH words. Pointers: head (read) and tail (write), each ADDR_WIDTH bits. Both wrap modulo depth by natural overflow. Count is kept in a separate ADDR_WIDTH+1 bit register.
- Reset (reset = 0, asynchronous):
  - head, tail and count clear to 0.
  - overflow and underflow clear to 0.
  - Outputs: empty = 1, full = 0, count = 0, data_out = 0.
  - Array contents are not cleared.
- en = 0: no state changes. Outputs keep reflecting the held state.
- en = 1, rising edge. Let do_push = push & (!full | pop) and do_pop = pop & !empty:
  - do_push: mem[tail] <= data_in; tail <= tail+1.
  - do_pop: head <= head+1.
  - count: +1 on push only, −1 on pop only, unchanged when both or neither.
  - push & full & !pop: write dropped, overflow <= 1.
  - pop & empty: pop ignored, underflow <= 1. If push is also asserted, the push proceeds.
  - push & pop & full: both accepted; count stays at full.
  - push & pop & empty: push only; count becomes 1; underflow <= 1.
- Flags full, empty and data_out are combinational from registered state only (head, count, mem). They never depend on same-cycle push/pop/data_in.
- Sticky flags clear only on reset.

## Timing
- Write-to-read latency: a word pushed at edge N appears on data_out immediately after edge N if the queue was empty before the edge.
- Pop at edge N: data_out shows the next entry immediately after edge N.
- No bypass: data_in never appears on data_out in the same cycle it is presented.
- Full throughput: one push and one pop per cycle, sustained.
- Reset is asynchronous assert. Deassertion must be synchronous to clk upstream.
- Reset mid-operation discards all entries. The first push after release lands at index 0.
- Pointer wrap from 2**ADDR_WIDTH−1 to 0 is seamless. Ordering is preserved across the wrap.

## Test plan
- Push 0x11, 0x12, 0x13, 0x14 on four edges, then pop each cycle -> data_out sequence is 0x11, 0x12, 0x13, 0x14, then empty = 1 and data_out = 0; count goes 4→0.
- Push 16 words 0x00..0x0F -> full = 1, count = 16. Push 0xAA -> overflow = 1, count stays 16. Pop all 16 -> data_out reads 0x00..0x0F, and 0xAA is never seen.
- Hold 3 entries, set en = 0 for 2 cycles with push = pop = 1 -> count, data_out and flags unchanged. Re-enable -> normal operation resumes.
- Hold 16 entries, then push+pop simultaneously for 20 cycles with incrementing data -> count stays 16, full stays 1, popped order is exact, and pointers wrap.
- Pop on empty -> underflow = 1. Simultaneous push 0x55 and pop on empty -> count = 1, data_out = 0x55.
- With 5 entries stored, assert reset = 0 between edges -> count = 0, empty = 1, flags = 0 immediately without waiting for a clock edge. After release, push 0x77 -> data_out = 0x77.
